// File: rtl/iir_deemph_pkg.sv
// Shared constants, state encoding and the dequantizer for the de-emphasis filter.
// Coefficient values match the C golden model.
package iir_deemph_pkg;

   localparam int DATA_SIZE = 32;
   localparam int BITS      = 10;

   localparam logic signed [DATA_SIZE-1:0] X0_COEFF = 32'sh000000B2;
   localparam logic signed [DATA_SIZE-1:0] X1_COEFF = 32'sh000000B2;
   localparam logic signed [DATA_SIZE-1:0] Y1_COEFF = 32'shFFFFFD66;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MULT  = 2'd1,
      S_SUM   = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   // Divide by 2^BITS rounding toward zero, as C integer division does.
   function automatic logic signed [DATA_SIZE-1:0] dequantize(input logic signed [63:0] p);
      logic signed [63:0] q;
      q = p >>> BITS;
      if (p[63] && (p[BITS-1:0] != '0)) begin
         q = q + 64'sd1;
      end
      return q[DATA_SIZE-1:0];
   endfunction

endpackage

// File: rtl/iir_deemph.sv
// Two-tap IIR de-emphasis core: y[n] = DEQ(X0*x[n]) + DEQ(X1*x[n-1]) + DEQ(Y1*y[n-1]).
// Pops a FWFT input FIFO, pushes one filtered sample every four cycles.
module iir_deemph
   import iir_deemph_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 x_in_empty,
   output logic                 x_in_rd_en,
   input  logic [DATA_SIZE-1:0] x_in_dout,
   input  logic                 y_out_full,
   output logic                 y_out_wr_en,
   output logic [DATA_SIZE-1:0] y_out_din
);

   state_t state_q, state_d;

   logic signed [DATA_SIZE-1:0] x0_q, x0_d;
   logic signed [DATA_SIZE-1:0] x1_q, x1_d;
   logic signed [DATA_SIZE-1:0] y1_q, y1_d;
   logic signed [DATA_SIZE-1:0] y_q,  y_d;
   logic signed [63:0]          p0_q, p0_d;
   logic signed [63:0]          p1_q, p1_d;
   logic signed [63:0]          p2_q, p2_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         y_q     <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         y_q     <= y_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      y_d         = y_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      x_in_rd_en  = 1'b0;
      y_out_wr_en = 1'b0;
      // Between writes the output shows the last sample written, which is y1.
      y_out_din   = y1_q;

      case (state_q)
         S_IDLE: begin
            if (!x_in_empty && !reset) begin
               x_in_rd_en = 1'b1;
               x0_d       = x_in_dout;
               state_d    = S_MULT;
            end
         end
         S_MULT: begin
            p0_d    = 64'(X0_COEFF) * 64'(x0_q);
            p1_d    = 64'(X1_COEFF) * 64'(x1_q);
            p2_d    = 64'(Y1_COEFF) * 64'(y1_q);
            state_d = S_SUM;
         end
         S_SUM: begin
            y_d     = dequantize(p0_q) + dequantize(p1_q) + dequantize(p2_q);
            state_d = S_WRITE;
         end
         S_WRITE: begin
            y_out_din = y_q;
            if (!y_out_full && !reset) begin
               y_out_wr_en = 1'b1;
               x1_d        = x0_q;
               y1_d        = y_q;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
